// File: rtl/ee214_arith_pkg.sv
// rtl/ee214_arith_pkg.sv - shared state encoding and nibble width for the serial ALU blocks
package ee214_arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/bla_sub_4bit.sv
// rtl/bla_sub_4bit.sv - combinational 4-bit borrow-lookahead subtractor, d = x - y - bin
module bla_sub_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Subtraction as x + ~y + ~bin; borrow is the inverted carry.
  assign g = x & ~y;
  assign p = x ^ ~y;

  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d    = p ^ c[3:0];
  assign bout = ~c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - nibble-serial A - B - BIN subtractor; SUB_OVERFLOW_FLAG_EN adds port v
module nibble_serial_subtractor
  import ee214_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             v
`endif
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  sub_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic             v_q, v_d;
`endif

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_d;
  logic                nib_bout;
  logic                last_nib;

  assign nib_a    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign last_nib = (idx_q == IDX_W'(N - 1));

  bla_sub_4bit u_sub (
    .x    (nib_a),
    .y    (nib_b),
    .bin  (borrow_q),
    .d    (nib_d),
    .bout (nib_bout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
`ifdef SUB_OVERFLOW_FLAG_EN
    v_d      = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
        end
      end
      RUN: begin
        diff_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_d;
        borrow_d = nib_bout;
        if (last_nib) begin
          state_d = DONE;
          idx_d   = '0;
          bout_d  = nib_bout;
          zero_d  = (diff_d == '0);
`ifdef SUB_OVERFLOW_FLAG_EN
          v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      v_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
`ifdef SUB_OVERFLOW_FLAG_EN
      v_q      <= v_d;
`endif
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
`ifdef SUB_OVERFLOW_FLAG_EN
  assign v    = v_q;
`endif

endmodule
